tl_phase_fsm: RTL and testbench
===============================

Name: tl_phase_fsm

Overview:
- Next-state logic and state register for the two-road traffic light controller (road A, road B). Directly upstream of the light-decoding output logic, which it feeds.
- Advances the 2-bit phase from traffic sensors Ta/Tb, enforcing minimum green, maximum green and fixed yellow durations.
- All durations are counted in ticks of an external 1-cycle enable pulse (prescaler), so timing is independent of clk.

Parameters:
- TW, 8: phase-counter width in bits.
- MIN_GREEN, 3: ticks a green phase is held before it may yield. Range 1..MAX_GREEN.
- MAX_GREEN, 6: ticks after which a green phase yields even if its own road still has traffic. Range MIN_GREEN..2^TW.
- YELLOW, 2: ticks spent in each yellow phase. Range 1..2^TW.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- tick  in  1  timing enable; 1-cycle pulse, may be tied high
- Ta  in  1  road A traffic present; already synchronised externally
- Tb  in  1  road B traffic present; already synchronised externally
- state  out  2  current phase, registered; consumed by the output logic
- phase_cnt  out  TW  ticks completed in the current phase, registered
- state_chg  out  1  registered pulse, high for 1 cycle after each phase change

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Reset has priority over tick.
- Reset values: state=2'b11 (A green), phase_cnt=0, state_chg=0.
- Phase encoding, shared with the output logic:
  - s3=2'b11: A green / B red
  - s0=2'b00: A yellow / B red
  - s1=2'b01: A red / B green
  - s2=2'b10: A red / B yellow
- Fixed cycle: s3 -> s0 -> s1 -> s2 -> s3. No other transitions exist.
- Evaluation timing: state and phase_cnt change only on a clk edge where tick=1. With tick=0 all registers hold, and state_chg is forced to 0 on that edge.
- Ta/Tb sampling: sampled only on tick cycles. Changes between ticks have no effect.
- phase_cnt counting, on each tick edge:
  - if the transition condition is true: state advances, phase_cnt <= 0, state_chg <= 1.
  - otherwise: phase_cnt increments, saturating at 2^TW-1, and state_chg <= 0.
- Transition conditions, evaluated with the pre-edge phase_cnt:
  - s3: (phase_cnt >= MIN_GREEN-1) && Tb && (!Ta || phase_cnt >= MAX_GREEN-1)
  - s0: phase_cnt == YELLOW-1, unconditional on sensors
  - s1: (phase_cnt >= MIN_GREEN-1) && Ta && (!Tb || phase_cnt >= MAX_GREEN-1)
  - s2: phase_cnt == YELLOW-1, unconditional on sensors
- Resting in green: with no demand from the opposing road, the green phase is held indefinitely and phase_cnt saturates.
- Resulting durations:
  - Yellow lasts exactly YELLOW ticks.
  - Green lasts at least MIN_GREEN ticks.
  - Green lasts at most MAX_GREEN ticks while the opposing road's sensor stays high.
- Sensor drop during yellow: does not abort the yellow; the next green is still entered.
- Reset mid-phase: the next edge returns to the reset values regardless of tick.
- Latency:
  - state updates on the tick edge where the condition is met.
  - The output logic is combinational on state, so lights change in that same cycle.
- Illegal encodings: none are possible with a 2-bit state. A default branch still returns to s3 for lint cleanliness.

Decomposition:
- Shared definitions file (tl_defs), also used by the output logic:
  - phase encodings S0..S3
  - light encodings RED=2'b00, YELLOW_L=2'b01, GREEN=2'b10
- Sub-module tl_phase_timer:
  - saturating TW-bit counter with tick enable and a synchronous clear input
  - comparator outputs min_done, max_done, yel_done
- tl_phase_fsm instantiates tl_phase_timer and holds the state register plus next-state logic.

Test Plan (MIN_GREEN=3, MAX_GREEN=6, YELLOW=2, TW=8):
1. Reset, tick=1 continuously, Ta=1, Tb=0 for 20 cycles -> state stays 11; phase_cnt=0,1,…,19; state_chg never 1.
2. Reset, tick=1, Ta=0, Tb=1 -> state sequence 11×3, 00×2, then 01, resting in 01; state_chg=1 on the cycle entering 00 and the cycle entering 01.
3. Reset, tick=1, Ta=Tb=1 -> state sequence 11×6, 00×2, 01×6, 10×2, then 11; pattern repeats with period 16.
4. As scenario 2 but with tick pulsed every 4th cycle -> each phase lasts 4× as many clk cycles (11 for 12 cycles, 00 for 8 cycles); nothing changes on non-tick edges.
5. Assert reset for 1 cycle while state=00 and phase_cnt=1 -> next edge gives state=11, phase_cnt=0, state_chg=0, even with tick=1 on that edge.
6. Ta=Tb=1, then drop Tb while in 00 -> 01 is still entered after 2 ticks; with Ta=1, Tb=0 the block leaves 01 after 3 ticks into 10, then 11.

Source files
------------

// File: rtl/tl_defs.sv
// Shared phase and light encodings for the two-road traffic light.
// Used by the phase FSM, its timer and the light-decoding output logic.
package tl_defs;

   // Phase encoding shared with the output logic
   typedef enum logic [1:0] {
      S0 = 2'b00,  // A yellow / B red
      S1 = 2'b01,  // A red / B green
      S2 = 2'b10,  // A red / B yellow
      S3 = 2'b11   // A green / B red
   } phase_e;

   // Light encoding consumed by the output logic
   typedef enum logic [1:0] {
      RED      = 2'b00,
      YELLOW_L = 2'b01,
      GREEN    = 2'b10
   } light_e;

   // Fixed cycle successor: S3 -> S0 -> S1 -> S2 -> S3
   function automatic phase_e next_phase(input phase_e p);
      unique case (p)
         S3:      next_phase = S0;
         S0:      next_phase = S1;
         S1:      next_phase = S2;
         S2:      next_phase = S3;
         default: next_phase = S3;
      endcase
   endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Saturating per-phase tick counter with synchronous clear and the
// min-green / max-green / yellow-done comparators.
module tl_phase_timer
   import tl_defs::*;
#(
   parameter int TW        = 8,
   parameter int MIN_GREEN = 3,
   parameter int MAX_GREEN = 6,
   parameter int YELLOW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick,
   input  logic          clr,
   output logic [TW-1:0] cnt,
   output logic          min_done,
   output logic          max_done,
   output logic          yel_done
);

   localparam logic [TW-1:0] MIN_M1 = TW'(MIN_GREEN - 1);
   localparam logic [TW-1:0] MAX_M1 = TW'(MAX_GREEN - 1);
   localparam logic [TW-1:0] YEL_M1 = TW'(YELLOW - 1);
   localparam logic [TW-1:0] SAT    = '1;

   logic [TW-1:0] r_cnt;

   // Count ticks in the current phase; clear wins, saturate at all-ones
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (tick) begin
         if (clr)
            r_cnt <= '0;
         else if (r_cnt != SAT)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cnt      = r_cnt;
   assign min_done = (r_cnt >= MIN_M1);
   assign max_done = (r_cnt >= MAX_M1);
   assign yel_done = (r_cnt == YEL_M1);

endmodule

// File: rtl/tl_phase_fsm.sv
// Phase register and next-state logic for the two-road traffic light.
// Advances only on prescaler ticks; green yields on opposing demand.
module tl_phase_fsm
   import tl_defs::*;
#(
   parameter int TW        = 8,
   parameter int MIN_GREEN = 3,
   parameter int MAX_GREEN = 6,
   parameter int YELLOW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick,
   input  logic          Ta,
   input  logic          Tb,
   output logic [1:0]    state,
   output logic [TW-1:0] phase_cnt,
   output logic          state_chg
);

   phase_e r_state;
   phase_e w_state_nxt;
   logic   r_chg;
   logic   w_adv;
   logic   w_min_done;
   logic   w_max_done;
   logic   w_yel_done;

   tl_phase_timer #(
      .TW        (TW),
      .MIN_GREEN (MIN_GREEN),
      .MAX_GREEN (MAX_GREEN),
      .YELLOW    (YELLOW)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .clr      (w_adv),
      .cnt      (phase_cnt),
      .min_done (w_min_done),
      .max_done (w_max_done),
      .yel_done (w_yel_done)
   );

   // Decide whether the current phase ends on this tick
   always_comb begin
      w_adv       = 1'b0;
      w_state_nxt = next_phase(r_state);
      unique case (r_state)
         S3: w_adv = w_min_done && Tb && (!Ta || w_max_done);
         S0: w_adv = w_yel_done;
         S1: w_adv = w_min_done && Ta && (!Tb || w_max_done);
         S2: w_adv = w_yel_done;
         default: begin
            w_adv       = 1'b1;
            w_state_nxt = S3;
         end
      endcase
   end

   // Phase register and one-cycle change pulse, updated on ticks only
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S3;
         r_chg   <= 1'b0;
      end else if (tick) begin
         if (w_adv)
            r_state <= w_state_nxt;
         r_chg <= w_adv;
      end else begin
         r_chg <= 1'b0;
      end
   end

   assign state     = r_state;
   assign state_chg = r_chg;

endmodule

// File: tb/tb_tl_phase_fsm.sv
// Directed bench for tl_phase_fsm: vector table plus multi-cycle
// sequences (resting green, full cycle, slow tick, saturation).
module tb_tl_phase_fsm;

   localparam int TW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          tick = 1'b0;
   logic          Ta = 1'b0;
   logic          Tb = 1'b0;
   logic [1:0]    state;
   logic [TW-1:0] phase_cnt;
   logic          state_chg;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       rst;
      logic       tk;
      logic       ta;
      logic       tb;
      logic [1:0] st;
      int         cnt;
      logic       chg;
   } vec_t;

   vec_t vq[$];

   tl_phase_fsm #(
      .TW(TW), .MIN_GREEN(3), .MAX_GREEN(6), .YELLOW(2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .Ta        (Ta),
      .Tb        (Tb),
      .state     (state),
      .phase_cnt (phase_cnt),
      .state_chg (state_chg)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic k, input logic a,
                      input logic b, input logic [1:0] s, input int c,
                      input logic g);
      vec_t v;
      v.rst = r; v.tk = k; v.ta = a; v.tb = b;
      v.st = s; v.cnt = c; v.chg = g;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [1:0] s,
                      input int c, input logic g);
      checks++;
      if (state !== s || int'(phase_cnt) != c || state_chg !== g) begin
         errors++;
         $display("FAIL %s: got st=%b cnt=%0d chg=%b, want st=%b cnt=%0d chg=%b",
                  nm, state, phase_cnt, state_chg, s, c, g);
      end
   endtask

   // drive inputs, take one edge, sample 1 time unit later
   task automatic step(input logic r, input logic k,
                       input logic a, input logic b);
      reset = r; tick = k; Ta = a; Tb = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int p;
      int k;
      logic [1:0] es;
      int ec;
      logic eg;

      // Scenario 2: B demand only, rests in B green
      add(1,1,0,1, 2'b11,0,0);
      add(0,1,0,1, 2'b11,1,0);
      add(0,1,0,1, 2'b11,2,0);
      add(0,1,0,1, 2'b00,0,1);
      add(0,0,0,1, 2'b00,0,0);
      add(0,1,0,1, 2'b00,1,0);
      add(0,1,0,1, 2'b01,0,1);
      add(0,1,0,1, 2'b01,1,0);
      add(0,1,0,1, 2'b01,2,0);
      add(0,1,0,1, 2'b01,3,0);
      // Scenario 5: reset while in 00 with cnt=1
      add(1,1,0,1, 2'b11,0,0);
      add(0,1,0,1, 2'b11,1,0);
      add(0,1,0,1, 2'b11,2,0);
      add(0,1,0,1, 2'b00,0,1);
      add(0,1,0,1, 2'b00,1,0);
      add(1,1,0,1, 2'b11,0,0);
      add(0,0,0,1, 2'b11,0,0);
      add(0,1,0,0, 2'b11,1,0);
      // Scenario 6: Tb drops during A yellow
      add(1,1,1,1, 2'b11,0,0);
      add(0,1,1,1, 2'b11,1,0);
      add(0,1,1,1, 2'b11,2,0);
      add(0,1,1,1, 2'b11,3,0);
      add(0,1,1,1, 2'b11,4,0);
      add(0,1,1,1, 2'b11,5,0);
      add(0,1,1,1, 2'b00,0,1);
      add(0,1,1,0, 2'b00,1,0);
      add(0,1,1,0, 2'b01,0,1);
      add(0,1,1,0, 2'b01,1,0);
      add(0,1,1,0, 2'b01,2,0);
      add(0,1,1,0, 2'b10,0,1);
      add(0,1,1,0, 2'b10,1,0);
      add(0,1,1,0, 2'b11,0,1);

      foreach (vq[i]) begin
         step(vq[i].rst, vq[i].tk, vq[i].ta, vq[i].tb);
         chk($sformatf("vec%0d", i), vq[i].st, vq[i].cnt, vq[i].chg);
      end

      // Scenario 1: A demand only, A green held, counter runs
      step(1,1,1,0);
      chk("s1_reset", 2'b11, 0, 0);
      for (int i = 1; i <= 19; i++) begin
         step(0,1,1,0);
         chk($sformatf("s1_c%0d", i), 2'b11, i, 0);
      end
      for (int i = 20; i < 300; i++)
         step(0,1,1,0);
      chk("s1_sat", 2'b11, 255, 0);

      // Scenario 3: both roads busy, period-16 cycle
      step(1,1,1,1);
      chk("s3_reset", 2'b11, 0, 0);
      for (int i = 1; i <= 32; i++) begin
         step(0,1,1,1);
         p = i % 16;
         if (p < 6) begin es = 2'b11; ec = p; end
         else if (p < 8) begin es = 2'b00; ec = p - 6; end
         else if (p < 14) begin es = 2'b01; ec = p - 8; end
         else begin es = 2'b10; ec = p - 14; end
         eg = (p == 0 || p == 6 || p == 8 || p == 14);
         chk($sformatf("s3_c%0d", i), es, ec, eg);
      end

      // Scenario 4: tick every 4th cycle, B demand only
      step(1,1,0,1);
      chk("s4_reset", 2'b11, 0, 0);
      for (int c = 1; c <= 40; c++) begin
         step(0, logic'(c % 4 == 0), 0, 1);
         k = c / 4;
         if (k < 3) begin es = 2'b11; ec = k; end
         else if (k < 5) begin es = 2'b00; ec = k - 3; end
         else begin es = 2'b01; ec = k - 5; end
         eg = (c % 4 == 0) && (k == 3 || k == 5);
         if (c == 12 || c == 20 || c == 13 || c == 40 || c % 3 == 0)
            chk($sformatf("s4_c%0d", c), es, ec, eg);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
